// File: rtl/reaction_stats.sv
// reaction_stats: post-processor for finished reaction-timer trials.
// Captures each result, keeps best time and trial statistics, and turns the
// selected value (last / best / average) into four BCD digits. The digits come
// from an iterative double-dabble converter that takes one shift per tick.
// Optional feature macro: REACT_AVG_EN adds a 4-deep history of normal times
// and a running sum, so that sel=10 shows the average.
module reaction_stats #(
  parameter int W_IN = 14
) (
  input  logic            ms_clk,
  input  logic            reset,
  input  logic            res_valid,
  input  logic [W_IN-1:0] res_time,
  input  logic [1:0]      res_kind,
  input  logic [1:0]      sel,
  input  logic            clr_stats,
  output logic            busy,
  output logic            bcd_valid,
  output logic [15:0]     bcd,
  output logic [W_IN-1:0] best,
  output logic [7:0]      trials,
  output logic            new_best,
  output logic            overrun
);

  localparam logic [W_IN-1:0] MAX_V   = W_IN'(9999);
  localparam logic [W_IN-1:0] SLOW_V  = W_IN'(1000);
  localparam logic [3:0]      LAST_IT = 4'(W_IN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_prev_q;
  logic            pending_q, pending_d;
  logic [W_IN-1:0] shift_q;
  logic [15:0]     scr_q;
  logic [3:0]      iter_q;
  logic [15:0]     bcd_q;
  logic            bcd_valid_q;
  logic [W_IN-1:0] last_q, last_d, best_q, best_d;
  logic [7:0]      trials_q, trials_d;
  logic            new_best_q, new_best_d;
  logic            overrun_q, overrun_d;
  logic            sel_chg, accept, load;
  logic [W_IN-1:0] src_val;
  logic [15:0]     scr_adj;

`ifdef REACT_AVG_EN
  logic [3:0][W_IN-1:0] hist_q, hist_d;
  logic [15:0]          sum_q, sum_d;
  logic [W_IN-1:0]      avg_val;
`endif

  function automatic logic [W_IN-1:0] clamp(input logic [W_IN-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Double-dabble correction: any digit >= 5 would overflow past 9 on the shift.
  function automatic logic [15:0] dabble(input logic [15:0] s);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    end
    return r;
  endfunction

  assign scr_adj = dabble(scr_q);

  // FSM state register
  always_ff @(posedge ms_clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: one conversion is W_IN shift cycles followed by DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_CONV;
      S_CONV:  if (iter_q == LAST_IT) state_d = S_DONE;
      S_DONE:  state_d = load ? S_CONV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy, result acceptance, load trigger, deferred sel reconversion
  always_comb begin
    busy      = (state_q != S_IDLE);
    accept    = res_valid && !busy;
    sel_chg   = (sel_q != sel_prev_q);
    load      = 1'b0;
    pending_d = pending_q;
    case (state_q)
      S_IDLE:  load = accept || sel_chg;
      S_CONV:  if (sel_chg) pending_d = 1'b1;
      S_DONE:  load = pending_q || sel_chg;
      default: load = 1'b0;
    endcase
    if (load) pending_d = 1'b0;
  end

  // Statistics next-state; clr_stats overrides whatever the trial would do
  always_comb begin
    last_d     = last_q;
    best_d     = best_q;
    trials_d   = trials_q;
    new_best_d = new_best_q;
    overrun_d  = overrun_q;
`ifdef REACT_AVG_EN
    hist_d     = hist_q;
    sum_d      = sum_q;
`endif
    if (accept) begin
      if (res_kind == 2'b00) begin
        last_d = clamp(res_time);
        if (trials_q != 8'hFF) trials_d = trials_q + 8'd1;
        new_best_d = (last_d < best_q);
        if (last_d < best_q) best_d = last_d;
`ifdef REACT_AVG_EN
        sum_d  = sum_q - 16'(hist_q[3]) + 16'(last_d);
        hist_d = {hist_q[2:0], last_d};
`endif
      end else begin
        last_d     = (res_kind == 2'b01) ? SLOW_V : MAX_V;
        new_best_d = 1'b0;
      end
    end
    if (res_valid && busy) overrun_d = 1'b1;
    if (clr_stats) begin
      best_d     = MAX_V;
      trials_d   = 8'd0;
      new_best_d = 1'b0;
      overrun_d  = 1'b0;
`ifdef REACT_AVG_EN
      hist_d     = '0;
      sum_d      = 16'd0;
`endif
    end
  end

`ifdef REACT_AVG_EN
  assign avg_val = (trials_d >= 8'd4) ? W_IN'(sum_d >> 2) : MAX_V;
`endif

  // Display source, taken from next-state values so a fresh trial shows at once
  always_comb begin
    case (sel_q)
      2'b01:   src_val = best_d;
`ifdef REACT_AVG_EN
      2'b10:   src_val = avg_val;
`endif
      default: src_val = last_d;
    endcase
  end

  // Statistics, sel history and converter datapath registers
  always_ff @(posedge ms_clk or posedge reset) begin
    if (reset) begin
      sel_q       <= 2'b00;
      sel_prev_q  <= 2'b00;
      pending_q   <= 1'b0;
      shift_q     <= '0;
      scr_q       <= 16'h0000;
      iter_q      <= 4'd0;
      bcd_q       <= 16'h0000;
      bcd_valid_q <= 1'b0;
      last_q      <= '0;
      best_q      <= MAX_V;
      trials_q    <= 8'd0;
      new_best_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef REACT_AVG_EN
      hist_q      <= '0;
      sum_q       <= 16'd0;
`endif
    end else begin
      sel_q       <= sel;
      sel_prev_q  <= sel_q;
      pending_q   <= pending_d;
      last_q      <= last_d;
      best_q      <= best_d;
      trials_q    <= trials_d;
      new_best_q  <= new_best_d;
      overrun_q   <= overrun_d;
`ifdef REACT_AVG_EN
      hist_q      <= hist_d;
      sum_q       <= sum_d;
`endif
      bcd_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) bcd_q <= scr_q;
      if (load) begin
        shift_q <= clamp(src_val);
        scr_q   <= 16'h0000;
        iter_q  <= 4'd0;
      end else if (state_q == S_CONV) begin
        {scr_q, shift_q} <= 30'({scr_adj, shift_q} << 1);
        iter_q           <= iter_q + 4'd1;
      end
    end
  end

  assign bcd_valid = bcd_valid_q;
  assign bcd       = bcd_q;
  assign best      = best_q;
  assign trials    = trials_q;
  assign new_best  = new_best_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_reaction_stats.sv
// Bench for reaction_stats: directed scenarios with literal expectations, then
// randomized trials, all outputs compared every cycle against a behavioural model.
module tb_reaction_stats;
  localparam int W_IN = 14;

  logic            ms_clk = 1'b0;
  logic            reset = 1'b1;
  logic            res_valid = 1'b0;
  logic [W_IN-1:0] res_time = '0;
  logic [1:0]      res_kind = 2'b00;
  logic [1:0]      sel = 2'b00;
  logic            clr_stats = 1'b0;
  logic            busy, bcd_valid, new_best, overrun;
  logic [15:0]     bcd;
  logic [W_IN-1:0] best;
  logic [7:0]      trials;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  reaction_stats #(.W_IN(W_IN)) dut (
    .ms_clk(ms_clk), .reset(reset), .res_valid(res_valid), .res_time(res_time),
    .res_kind(res_kind), .sel(sel), .clr_stats(clr_stats), .busy(busy),
    .bcd_valid(bcd_valid), .bcd(bcd), .best(best), .trials(trials),
    .new_best(new_best), .overrun(overrun)
  );

  always #5 ms_clk = ~ms_clk;

  // Behavioural model: a countdown to the result instead of a state machine
  int m_last = 0, m_best = 9999, m_trials = 0, m_cnt = 0, m_conv = 0, m_bcd = 0;
  int m_sel = 0, m_selp = 0;
  bit m_nb = 0, m_ovr = 0, m_bv = 0, m_pend = 0;
  int m_hist[$];

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int m_avg();
    int s = 0;
    if (m_trials < 4) return 9999;
    foreach (m_hist[i]) s += m_hist[i];
    return s / 4;
  endfunction

  function automatic int m_src(input int s);
    if (s == 1) return m_best;
`ifdef REACT_AVG_EN
    if (s == 2) return m_avg();
`endif
    return m_last;
  endfunction

  task automatic model_reset();
    m_last = 0; m_best = 9999; m_trials = 0; m_cnt = 0; m_conv = 0; m_bcd = 0;
    m_sel = 0; m_selp = 0; m_nb = 0; m_ovr = 0; m_bv = 0; m_pend = 0;
    m_hist.delete();
  endtask

  task automatic model_step();
    bit busy_pre, selchg, acc, done, doload;
    int v;
    busy_pre = (m_cnt > 0);
    selchg   = (m_sel != m_selp);
    acc      = res_valid && !busy_pre;
    m_bv     = 1'b0;
    if (acc) begin
      if (res_kind == 2'b00) begin
        v = (int'(res_time) > 9999) ? 9999 : int'(res_time);
        m_last = v;
        if (m_trials < 255) m_trials++;
        m_nb = (v < m_best);
        if (v < m_best) m_best = v;
        m_hist.push_back(v);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
      end else begin
        m_last = (res_kind == 2'b01) ? 1000 : 9999;
        m_nb = 1'b0;
      end
    end
    if (res_valid && busy_pre) m_ovr = 1'b1;
    if (clr_stats) begin
      m_best = 9999; m_trials = 0; m_nb = 1'b0; m_ovr = 1'b0;
      m_hist.delete();
    end
    done = (m_cnt == 1);
    if (done) begin
      m_bcd = to_bcd(m_conv);
      m_bv  = 1'b1;
    end
    doload = (!busy_pre && (acc || selchg)) || (done && (m_pend || selchg));
    if (doload) begin
      m_pend = 1'b0;
      m_cnt  = 15;
      m_conv = m_src(m_sel);
    end else begin
      if (busy_pre && selchg) m_pend = 1'b1;
      if (m_cnt > 0) m_cnt--;
    end
    m_selp = m_sel;
    m_sel  = int'(sel);
  endtask

  initial forever begin
    @(posedge ms_clk or posedge reset);
    if (reset) model_reset();
    else       model_step();
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge ms_clk);
    if (chk_en) begin
      cmp("busy",      int'(busy),      (m_cnt > 0) ? 1 : 0);
      cmp("bcd_valid", int'(bcd_valid), int'(m_bv));
      cmp("bcd",       int'(bcd),       m_bcd);
      cmp("best",      int'(best),      m_best);
      cmp("trials",    int'(trials),    m_trials);
      cmp("new_best",  int'(new_best),  int'(m_nb));
      cmp("overrun",   int'(overrun),   int'(m_ovr));
    end
  end

  task automatic send(input logic [1:0] k, input int t);
    res_kind  = k;
    res_time  = W_IN'(t);
    res_valid = 1'b1;
    @(negedge ms_clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_bv(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge ms_clk);
      if (bcd_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_bv: no bcd_valid within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    int lat;
    int r, kk;
    repeat (3) @(negedge ms_clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    cmp("rst_bcd",    int'(bcd),    16'h0000);
    cmp("rst_best",   int'(best),   9999);
    cmp("rst_trials", int'(trials), 0);
    cmp("rst_busy",   int'(busy),   0);

    // Normal 237 on sel=last
    send(2'b00, 237);
    wait_bv(lat);
    cmp("lat_237",  lat,            15);
    cmp("bcd_237",  int'(bcd),      16'h0237);
    cmp("best_237", int'(best),     237);
    cmp("trl_237",  int'(trials),   1);
    cmp("nb_237",   int'(new_best), 1);

    // Too slow, cheat, kind 11
    send(2'b01, 4000); wait_bv(lat);
    cmp("bcd_slow", int'(bcd), 16'h1000);
    send(2'b10, 12);   wait_bv(lat);
    cmp("bcd_cheat", int'(bcd), 16'h9999);
    send(2'b11, 5);    wait_bv(lat);
    cmp("bcd_k11",   int'(bcd),      16'h9999);
    cmp("best_nn",   int'(best),     237);
    cmp("trl_nn",    int'(trials),   1);
    cmp("nb_nn",     int'(new_best), 0);

    // 500 then 180, then show best
    send(2'b00, 500); wait_bv(lat);
    send(2'b00, 180); wait_bv(lat);
    sel = 2'b01;      wait_bv(lat);
    cmp("bcd_best180", int'(bcd),      16'h0180);
    cmp("best_180",    int'(best),     180);
    cmp("nb_180",      int'(new_best), 1);

    // Equal time does not count as a new best
    sel = 2'b00;      wait_bv(lat);
    send(2'b00, 180); wait_bv(lat);
    cmp("nb_eq",   int'(new_best), 0);
    cmp("best_eq", int'(best),     180);

    // Result arriving mid-conversion is dropped
    send(2'b00, 42);
    repeat (4) @(negedge ms_clk);
    send(2'b00, 777);
    wait_bv(lat);
    cmp("bcd_ovr",  int'(bcd),     16'h0042);
    cmp("ovr_set",  int'(overrun), 1);
    cmp("trl_ovr",  int'(trials),  5);
    cmp("best_ovr", int'(best),    42);
    repeat (20) @(negedge ms_clk);

    // Clear statistics, then average display
    clr_stats = 1'b1;
    @(negedge ms_clk);
    clr_stats = 1'b0;
    cmp("ovr_clr",  int'(overrun), 0);
    cmp("best_clr", int'(best),    9999);
    cmp("trl_clr",  int'(trials),  0);
    sel = 2'b10; wait_bv(lat);
    send(2'b00, 100); wait_bv(lat);
    send(2'b00, 200); wait_bv(lat);
    send(2'b00, 300); wait_bv(lat);
`ifdef REACT_AVG_EN
    cmp("avg_3", int'(bcd), 16'h9999);
`else
    cmp("avg_3", int'(bcd), 16'h0300);
`endif
    send(2'b00, 400); wait_bv(lat);
`ifdef REACT_AVG_EN
    cmp("avg_4", int'(bcd), 16'h0250);
`else
    cmp("avg_4", int'(bcd), 16'h0400);
`endif

    // Reset in the middle of a conversion
    sel = 2'b00; wait_bv(lat);
    send(2'b00, 55);
    repeat (5) @(negedge ms_clk);
    #2 reset = 1'b1;
    @(negedge ms_clk);
    cmp("mrst_busy", int'(busy),      0);
    cmp("mrst_bcd",  int'(bcd),       16'h0000);
    cmp("mrst_best", int'(best),      9999);
    cmp("mrst_trl",  int'(trials),    0);
    cmp("mrst_bv",   int'(bcd_valid), 0);
    @(negedge ms_clk);
    reset = 1'b0;

    // Randomized trials
    for (int c = 0; c < 4000; c++) begin
      res_valid = ($urandom_range(0, 9) == 0);
      kk        = $urandom_range(0, 9);
      res_kind  = (kk < 6) ? 2'b00 : 2'(kk - 6);
      r         = $urandom_range(0, 9);
      if (r == 0)      res_time = W_IN'(9999);
      else if (r == 1) res_time = W_IN'(10000 + $urandom_range(0, 6383));
      else if (r == 2) res_time = W_IN'(m_best);
      else             res_time = W_IN'($urandom_range(0, 9999));
      if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
      clr_stats = ($urandom_range(0, 149) == 0);
      if (c == 2000) begin
        #2 reset = 1'b1;
        @(negedge ms_clk);
        reset = 1'b0;
      end
      @(negedge ms_clk);
    end
    res_valid = 1'b0;
    clr_stats = 1'b0;
    repeat (40) @(negedge ms_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_stats.md
# reaction_stats

Result post-processor sitting directly downstream of the reaction-timer state machine. It accepts each finished trial (reaction time in ms plus outcome kind), keeps best-time and trial statistics, and converts the selected value to four BCD digits with an iterative double-dabble converter. The BCD word drives the 4-digit seven-segment path, so the display shows decimal milliseconds instead of raw hex.

## Interface
- W_IN, 14: binary input width; covers 0..9999.
- ms_clk  in  1  1 kHz system tick clock.
- reset  in  1  asynchronous, active-high.
- res_valid  in  1  one-cycle pulse; res_time/res_kind valid.
- res_time  in  W_IN  reaction time, ms.
- res_kind  in  2  00 normal, 01 too slow, 10 cheat, 11 treated as cheat.
- sel  in  2  display source: 00 last, 01 best, 10 average, 11 last.
- clr_stats  in  1  level; clears best, trials, average history, new_best, overrun.
- busy  out  1  converter running.
- bcd_valid  out  1  one-cycle pulse; bcd updated this cycle.
- bcd  out  16  {thousands, hundreds, tens, ones} BCD.
- best  out  W_IN  best normal time; 9999 when none.
- trials  out  8  count of normal trials, saturates at 255.
- new_best  out  1  last normal trial set a new best; held until next accepted res_valid.
- overrun  out  1  sticky: res_valid arrived while busy.

## Operation
- Reset values: busy 0, bcd_valid 0, bcd 16'h0000, best 9999, trials 0, new_best 0, overrun 0, last 0, state IDLE.
- Result capture (only when not busy): normal -> last = min(res_time, 9999); too slow -> last = 1000; cheat/11 -> last = 9999.
- Normal trial only: trials += 1 (saturating); if last < best, best = last and new_best = 1, else new_best = 0; equal time does not update best. Non-normal trials leave best, trials, average untouched and clear new_best.
- res_valid while busy: result dropped, overrun set, running conversion unaffected.
- clr_stats has priority over a simultaneous res_valid for statistics: stats cleared, result still captured into last and converted.
- Conversion trigger: accepted res_valid, or change of registered sel. sel change while busy sets pending; one reconversion starts the cycle after bcd_valid, using current sel.
- Source mux sampled at load: last, best, or average (sel=10 without REACT_AVG_EN selects last).
- FSM: IDLE -> CONV on trigger (load 14-bit value into shift register, clear 16-bit BCD scratch, iter=0) -> CONV 14 cycles (each: add 3 to every BCD nibble >= 5, then shift left one, iter+1) -> DONE (copy scratch to bcd, pulse bcd_valid) -> IDLE, or -> CONV if pending.
- Width rules: all inputs clamped to 9999 before load, so thousands digit never exceeds 9.

## Timing
- Edge k samples res_valid: load, busy=1 after edge k.
- Edges k+1..k+14: shift iterations.
- Edge k+15: bcd updated, bcd_valid=1, busy=0 (unless pending); bcd_valid low after edge k+16.
- Statistics (best, trials, new_best) update at edge k, before conversion completes.
- sel change sampled at edge j in IDLE: load at edge j+1, bcd at edge j+16.
- Reset mid-conversion: immediate return to reset values; partial result discarded.

## Configuration
- REACT_AVG_EN defined: 4-entry history of normal times plus 16-bit running sum; average = sum >> 2 once trials >= 4, else 9999; history and sum cleared by clr_stats/reset.
- REACT_AVG_EN undefined: no history or sum logic; sel=10 behaves as sel=00.

## Test plan
- Reset, normal 237, sel=00 -> bcd 16'h0237 pulsed 15 cycles after res_valid; best 237, trials 1, new_best 1.
- Then too slow, then cheat -> bcd 16'h1000, then 16'h9999; best 237, trials 1, new_best 0.
- Normal 500 then 180, sel=01 -> best 180, new_best 1; sel change reconverts to 16'h0180.
- res_valid at edge k+5 of a running conversion -> overrun 1, first result completes unchanged, second not captured.
- REACT_AVG_EN, normals 100,200,300,400, sel=10 -> bcd 16'h0250; after 3 trials average shows 16'h9999.
- Reset asserted mid-CONV -> busy 0, bcd 16'h0000, best 9999, trials 0, no bcd_valid pulse.
